cache_ctrl: RTL and testbench

//  Miss/store sequencer between the MEM-stage load/store unit, the 2-way data cache and data memory.

---
 rtl/cache_pkg.sv | 8 +
 rtl/sat_counter.sv | 19 +
 rtl/cache_ctrl.sv | 123 ++++++++++++
 tb/tb_cache_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and default widths for the data-cache miss/store sequencer.
package cache_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {IDLE, RD_WAIT, FILL, WR_WAIT} state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance-debug hit/miss counts.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] r_cnt;

  // Holds at all-ones instead of wrapping so a long run never reads as a small count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_cnt <= '0;
    else if (inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  assign cnt = r_cnt;
endmodule

// File: rtl/cache_ctrl.sv
// Miss/store sequencer between the MEM-stage LSU, a 2-way data cache and data memory.
// Load misses fetch over a req/ack port and refill; stores are write-through.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_req,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              cache_hit,
  output logic              stall,
  output logic              fill_en,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              cache_st_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  state_e            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              r_hit;
  logic              w_stall, w_hit_inc, w_miss_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_stall     = 1'b0;
    fill_en     = 1'b0;
    cache_st_en = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    w_hit_inc   = 1'b0;
    w_miss_inc  = 1'b0;
    case (r_state)
      IDLE: begin
        // A simultaneous load is dropped: the store wins and nothing replays the load.
        if (st_req) begin
          w_stall = 1'b1;
          w_next  = WR_WAIT;
        end else if (ld_req) begin
          if (cache_hit) begin
            w_hit_inc = 1'b1;
          end else begin
            w_stall    = 1'b1;
            w_miss_inc = 1'b1;
            w_next     = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        mem_req = 1'b1;
        w_stall = 1'b1;
        if (mem_ack) w_next = FILL;
      end
      FILL: begin
        fill_en = 1'b1;
        w_stall = 1'b1;
        w_next  = IDLE;
      end
      WR_WAIT: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          cache_st_en = r_hit;
          w_next      = IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_hit   <= 1'b0;
    end else begin
      if (r_state == IDLE && st_req) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_hit   <= cache_hit;
      end else if (r_state == IDLE && ld_req && !cache_hit) begin
        r_addr <= addr;
      end
      if (r_state == RD_WAIT && mem_ack) r_rdata <= mem_rdata;
    end
  end

  // Stall is combinational on ld_req/cache_hit, so mask it while reset is held.
  assign stall     = w_stall & rst_n;
  assign fill_addr = r_addr;
  assign fill_data = r_rdata;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk(clk), .rst_n(rst_n), .inc(w_hit_inc), .cnt(hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk(clk), .rst_n(rst_n), .inc(w_miss_inc), .cnt(miss_cnt)
  );
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: directed scenarios plus random load/store traffic scored against
// an abstract model (set of cached words, memory map, saturating hit/miss tallies).
module tb_cache_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_req, st_req, cache_hit, mem_ack;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, mem_rdata;
  logic          stall, fill_en, cache_st_en, mem_req, mem_we;
  logic [AW-1:0] fill_addr, mem_addr;
  logic [DW-1:0] fill_data, mem_wdata;
  logic [CW-1:0] hit_cnt, miss_cnt;

  cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ld_req(ld_req), .st_req(st_req), .addr(addr),
    .wdata(wdata), .cache_hit(cache_hit), .stall(stall), .fill_en(fill_en),
    .fill_addr(fill_addr), .fill_data(fill_data), .cache_st_en(cache_st_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] mem    [logic [31:0]];
  bit          cached [logic [31:0]];
  int          m_hits, m_misses;
  bit          m_hit;
  int          e_stall, e_req, e_fill, e_sten;
  logic [31:0] e_fd;

  // Observations of one access
  int          ob_stall, ob_req, ob_fill, ob_sten, ob_bus_bad;
  logic [31:0] ob_fa, ob_fd;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], 16'hC0DE};
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Latency is counted as the number of cycles mem_req is high, ack on the last one.
  // Miss: one accept cycle + those cycles + the fill cycle. Store: stall drops in the ack cycle.
  task automatic model_step(input bit ld, input bit st, input logic [31:0] a,
                            input logic [31:0] d, input int lat);
    m_hit = cached.exists(a);
    e_fill = 0; e_sten = 0; e_fd = '0;
    if (st) begin
      e_stall = lat; e_req = lat; e_sten = m_hit ? 1 : 0;
      mem[a] = d;
    end else if (ld && m_hit) begin
      e_stall = 0; e_req = 0;
      m_hits = sat(m_hits + 1);
    end else begin
      e_stall = lat + 2; e_req = lat; e_fill = 1; e_fd = mem_rd(a);
      m_misses = sat(m_misses + 1);
      m_hits   = sat(m_hits + 1);
      cached[a] = 1'b1;
    end
  endtask

  // Drives one access as LSU + memory responder + cache lookup, until stall drops.
  task automatic access(input bit ld, input bit st, input logic [31:0] a,
                        input logic [31:0] d, input bit hit_in, input int lat);
    int cyc = 0;
    bit fin = 0;
    ob_stall = 0; ob_req = 0; ob_fill = 0; ob_sten = 0; ob_bus_bad = 0;
    ob_fa = '0; ob_fd = '0;
    ld_req = ld; st_req = st; addr = a; wdata = d; cache_hit = hit_in; mem_ack = 1'b0;
    while (!fin) begin
      if (mem_req) begin
        ob_req++;
        if (ob_req == lat) begin
          mem_ack = 1'b1;
          mem_rdata = mem_rd(a);
        end
      end
      #1;
      if (stall) ob_stall++; else fin = 1;
      if (mem_req && (mem_we !== st || mem_addr !== a || (st && mem_wdata !== d))) ob_bus_bad++;
      if (fill_en) begin ob_fill++; ob_fa = fill_addr; ob_fd = fill_data; end
      if (cache_st_en) ob_sten++;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (ob_fill > 0 && ld && !st) cache_hit = 1'b1;
      cyc++;
      if (!fin && cyc > 40) begin
        total++; bad++;
        $display("FAIL access_timeout addr=%h stall still high after %0d cycles", a, cyc);
        fin = 1;
      end
    end
    ld_req = 1'b0; st_req = 1'b0; cache_hit = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld_req = 1'b1; st_req = 1'b0; addr = 32'h40; wdata = '0;
    cache_hit = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({stall, mem_req, mem_we, fill_en, cache_st_en} !== 5'b0) begin bad++;
      $display("FAIL reset_ctl got=%b want=00000", {stall, mem_req, mem_we, fill_en, cache_st_en}); end
    total++; if ({hit_cnt, miss_cnt} !== '0) begin bad++;
      $display("FAIL reset_cnt hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt); end
    total++; if ({fill_addr, fill_data, mem_addr, mem_wdata} !== '0) begin bad++;
      $display("FAIL reset_latch fa=%h fd=%h ma=%h mw=%h want 0", fill_addr, fill_data, mem_addr, mem_wdata); end
    m_hits = 0; m_misses = 0;
    cached[32'h40] = 1'b1;
    cache_hit = 1'b1;
    rst_n = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_hit_stall got=%b want=0", stall); end
    @(posedge clk); #1;
    m_hits = 1;
    total++; if (hit_cnt !== 4'(m_hits)) begin bad++;
      $display("FAIL reset_hit_cnt got=%0d want=%0d", hit_cnt, m_hits); end
    ld_req = 1'b0; cache_hit = 1'b0;
  endtask

  task automatic test_load_miss();
    mem[32'h100] = 32'hDEADBEEF;
    model_step(1, 0, 32'h100, 0, 3);
    access(1, 0, 32'h100, 0, m_hit, 3);
    total++; if (ob_stall !== 5) begin bad++; $display("FAIL miss_stall got=%0d want=5", ob_stall); end
    total++; if (ob_fill !== 1 || ob_fa !== 32'h100 || ob_fd !== 32'hDEADBEEF) begin bad++;
      $display("FAIL miss_fill n=%0d addr=%h data=%h want 1/00000100/deadbeef", ob_fill, ob_fa, ob_fd); end
    total++; if (ob_bus_bad !== 0 || ob_req !== 3) begin bad++;
      $display("FAIL miss_bus bad=%0d req=%0d want 0/3", ob_bus_bad, ob_req); end
    total++; if (miss_cnt !== 4'(m_misses) || hit_cnt !== 4'(m_hits)) begin bad++;
      $display("FAIL miss_cnt miss=%0d hit=%0d want %0d/%0d", miss_cnt, hit_cnt, m_misses, m_hits); end
  endtask

  task automatic test_store();
    cached[32'h20] = 1'b1;
    model_step(0, 1, 32'h20, 32'hA5, 1);
    access(0, 1, 32'h20, 32'hA5, m_hit, 1);
    total++; if (ob_bus_bad !== 0 || ob_req !== 1) begin bad++;
      $display("FAIL store_bus bad=%0d req=%0d want 0/1", ob_bus_bad, ob_req); end
    total++; if (ob_sten !== 1 || ob_stall !== e_stall) begin bad++;
      $display("FAIL store_hit sten=%0d stall=%0d want 1/%0d", ob_sten, ob_stall, e_stall); end
    model_step(0, 1, 32'h28, 32'hA5, 1);
    access(0, 1, 32'h28, 32'hA5, m_hit, 1);
    total++; if (ob_sten !== 0 || ob_bus_bad !== 0) begin bad++;
      $display("FAIL store_miss sten=%0d bus_bad=%0d want 0/0", ob_sten, ob_bus_bad); end
  endtask

  task automatic test_reset_mid();
    cached.delete(32'h300);
    ld_req = 1'b1; addr = 32'h300; cache_hit = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rmid_req_before got=%b want=1", mem_req); end
    rst_n = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin bad++;
      $display("FAIL rmid_async req=%b stall=%b want 0/0", mem_req, stall); end
    m_hits = 0; m_misses = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; ld_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (fill_en !== 1'b0 || mem_req !== 1'b0) begin bad++;
        $display("FAIL rmid_late_ack cyc=%0d fill=%b req=%b want 0/0", i, fill_en, mem_req); end
      @(posedge clk); #1;
    end
    total++; if (hit_cnt !== 4'(m_hits) || miss_cnt !== 4'(m_misses)) begin bad++;
      $display("FAIL rmid_cnt hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) cached[32'h1000 + 32'(i * 4)] = 1'b1;
    ld_req = 1'b1; cache_hit = 1'b1;
    for (int i = 0; i < 20; i++) begin
      addr = 32'h1000 + 32'(i * 4);
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL sat_stall i=%0d got=%b want=0", i, stall); end
      @(posedge clk); #1;
      m_hits = sat(m_hits + 1);
      total++; if (hit_cnt !== 4'(m_hits)) begin bad++;
        $display("FAIL sat_cnt i=%0d got=%0d want=%0d", i, hit_cnt, m_hits); end
    end
    ld_req = 1'b0; cache_hit = 1'b0;
  endtask

  task automatic test_ld_st_conflict();
    cached.delete(32'h60);
    model_step(1, 1, 32'h60, 32'h0BAD_F00D, 2);
    access(1, 1, 32'h60, 32'h0BAD_F00D, m_hit, 2);
    total++; if (ob_bus_bad !== 0 || ob_fill !== 0 || ob_stall !== e_stall) begin bad++;
      $display("FAIL conflict bus_bad=%0d fill=%0d stall=%0d want 0/0/%0d", ob_bus_bad, ob_fill, ob_stall, e_stall); end
    total++; if (miss_cnt !== 4'(m_misses)) begin bad++;
      $display("FAIL conflict_cnt miss=%0d want=%0d", miss_cnt, m_misses); end
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    total++; if ({stall, mem_req, fill_en, cache_st_en} !== 4'b0) begin bad++;
      $display("FAIL spurious_ack got=%b want=0000", {stall, mem_req, fill_en, cache_st_en}); end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    total++; if ({stall, mem_req, fill_en, cache_st_en} !== 4'b0) begin bad++;
      $display("FAIL spurious_ack_next got=%b want=0000", {stall, mem_req, fill_en, cache_st_en}); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int op = int'($urandom_range(0, 7));
      int lat = int'($urandom_range(1, 4));
      logic [31:0] a = 32'h2000 + 32'($urandom_range(0, 11) * 4);
      logic [31:0] d = $urandom;
      bit ld = (op < 4) || (op == 7);
      bit st = (op >= 4);
      model_step(ld, st, a, d, lat);
      access(ld, st, a, d, m_hit, lat);
      total++; if (ob_stall !== e_stall || ob_req !== e_req) begin bad++;
        $display("FAIL rnd_timing n=%0d stall=%0d req=%0d want %0d/%0d", n, ob_stall, ob_req, e_stall, e_req); end
      total++; if (ob_fill !== e_fill || (e_fill == 1 && (ob_fa !== a || ob_fd !== e_fd))) begin bad++;
        $display("FAIL rnd_fill n=%0d n_fill=%0d fa=%h fd=%h want %0d/%h/%h", n, ob_fill, ob_fa, ob_fd, e_fill, a, e_fd); end
      total++; if (ob_sten !== e_sten || ob_bus_bad !== 0) begin bad++;
        $display("FAIL rnd_store n=%0d sten=%0d bus_bad=%0d want %0d/0", n, ob_sten, ob_bus_bad, e_sten); end
      total++; if (hit_cnt !== 4'(m_hits) || miss_cnt !== 4'(m_misses)) begin bad++;
        $display("FAIL rnd_cnt n=%0d hit=%0d miss=%0d want %0d/%0d", n, hit_cnt, miss_cnt, m_hits, m_misses); end
    end
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_store();
    test_reset_mid();
    test_saturate();
    test_ld_st_conflict();
    // Restart counters so random traffic also covers the unsaturated range.
    rst_n = 1'b0; m_hits = 0; m_misses = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
